// File: rtl/pipe_elastic_chain.sv
// Elastic register chain of DEPTH stages with collapsing bubbles,
// synchronous flush and a registered occupancy count.
module pipe_elastic_chain #(
    parameter int  W_DATA = 32,
    parameter int  DEPTH  = 4,
    localparam int W_CNT  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_DATA-1:0] o_data,
    input  logic              i_flush,
    output logic [W_CNT-1:0]  o_count
);

    // Handshake: a word moves across an interface on a rising edge exactly when
    // valid and ready are both high; valid never depends on ready of the same side.
    logic [DEPTH-1:0]  v_q, v_d;
    logic [W_DATA-1:0] d_q [DEPTH];
    logic [W_DATA-1:0] d_d [DEPTH];
    logic [W_CNT-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  rdy;
    logic              in_fire;
    logic              out_fire;

    // A stage may load when it or any stage downstream of it has room.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = i_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain  = ~v_q[k] | chain;
            rdy[k] = chain;
        end
    end

    assign o_ready  = rdy[0] & ~i_flush;
    assign o_valid  = v_q[DEPTH-1];
    assign o_data   = d_q[DEPTH-1];
    assign o_count  = count_q;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end
        if (rdy[0]) begin
            v_d[0] = in_fire;
            d_d[0] = i_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
        // Flush wins over every load; data registers may keep stale payload.
        if (i_flush) begin
            v_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + W_CNT'(1);
        end else if (!in_fire && out_fire) begin
            count_d = count_q - W_CNT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Randomised and directed bench for pipe_elastic_chain against a queue model
// in which each held word carries its position along the chain.
module tb_pipe_elastic_chain;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int WC = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_flush = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          o_ready;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic [WC-1:0] o_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model: exp_q holds the words in the chain (oldest first), pos_q their stage.
  logic [W-1:0] exp_q[$];
  int           pos_q[$];

  pipe_elastic_chain #(.W_DATA(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .resetn  (resetn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .i_flush (i_flush),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    logic ev, er, in_f, out_f;
    int   lim, np;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (pos_q[0] == D - 1);
    er = !f && ((exp_q.size() < D) || r);
    check_eq("o_valid", 32'(o_valid), 32'(ev));
    check_eq("o_ready", 32'(o_ready), 32'(er));
    check_eq("o_count", 32'(o_count), 32'(exp_q.size()));
    if (ev) check_eq("o_data", o_data, exp_q[0]);
    in_f  = v && er;
    out_f = ev && r;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
      pos_q.delete();
    end else begin
      if (out_f) begin
        void'(exp_q.pop_front());
        void'(pos_q.pop_front());
      end
      lim = D - 1;
      foreach (pos_q[i]) begin
        np = pos_q[i] + 1;
        if (np > lim) np = lim;
        pos_q[i] = np;
        lim = np - 1;
      end
      if (in_f) begin
        exp_q.push_back(d);
        pos_q.push_back(0);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * D; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_o_valid", 32'(o_valid), 32'd0);
    check_eq("rst_o_count", 32'(o_count), 32'd0);
    check_eq("rst_o_data", o_data, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Stream with downstream always ready
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    drain();

    // Fill under stall, then release
    for (int i = 0; i < 6; i++) step(1'b1, W'(32'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse
    step(1'b1, W'(32'h11), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, W'(32'h22), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    check_eq("bubble_count", 32'(o_count), 32'd2);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Simultaneous in/out at full
    for (int i = 0; i < D; i++) step(1'b1, W'(32'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, W'(32'hC0 + i), 1'b1, 1'b0);
    drain();

    // Flush mid-stream with input and output both requesting
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hD0 + i), 1'b0, 1'b0);
    step(1'b1, W'(32'hFF), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Asynchronous reset while full
    for (int i = 0; i < D; i++) step(1'b1, W'(32'hE0 + i), 1'b0, 1'b0);
    i_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check_eq("arst_o_valid", 32'(o_valid), 32'd0);
    check_eq("arst_o_count", 32'(o_count), 32'd0);
    check_eq("arst_o_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    pos_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 5; i <= 7; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 70, W'($urandom()),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
